// File: rtl/regfile_result_checker.sv
// regfile_result_checker
//
// Hardware end-of-program checker for the pipelined cpu. After a start pulse
// it lets the program run for a programmable number of cycles (or until the
// cpu signals halt), then walks a small table of (register, expected value)
// entries through a spare register-file read port and reports pass/fail,
// the number of mismatching entries, and the first mismatch seen.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cfg_we/idx/en/reg/val  table entry write (ignored while busy)
//   run_cycles          program run length; WAIT lasts run_cycles+1 cycles
//   start               single-cycle pulse, accepted in IDLE or DONE
//   halt                early end of program, only honoured in WAIT
//   rf_addr / rf_data   register-file read port (rf_data is combinational)
//   busy, done, pass    status; results hold until the next start
//   fail_count          number of enabled entries that mismatched
//   first_fail_idx      lowest mismatching entry index
//   first_fail_actual   register value observed for that entry
module regfile_result_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CHECKS     = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]     cfg_idx,
    input  logic                              cfg_en,
    input  logic [REG_ADDR_WIDTH-1:0]         cfg_reg,
    input  logic [DATA_WIDTH-1:0]             cfg_val,
    input  logic [CNT_WIDTH-1:0]              run_cycles,
    input  logic                              start,
    input  logic                              halt,
    output logic [REG_ADDR_WIDTH-1:0]         rf_addr,
    input  logic [DATA_WIDTH-1:0]             rf_data,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]     first_fail_idx,
    output logic [DATA_WIDTH-1:0]             first_fail_actual
);

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int FC_W  = $clog2(NUM_CHECKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                    state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [IDX_W-1:0]          idx;

    logic                      tbl_en  [NUM_CHECKS];
    logic [REG_ADDR_WIDTH-1:0] tbl_reg [NUM_CHECKS];
    logic [DATA_WIDTH-1:0]     tbl_val [NUM_CHECKS];

    logic                      table_open;
    logic                      mismatch;

    // The table is only writable while no run is in progress, so a check
    // always sees the entries as they were when the run was started (plus
    // any write issued in the same cycle as start).
    assign table_open = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_en[i]  <= 1'b0;
                tbl_reg[i] <= '0;
                tbl_val[i] <= '0;
            end
        end else if (cfg_we && table_open) begin
            tbl_en[cfg_idx]  <= cfg_en;
            tbl_reg[cfg_idx] <= cfg_reg;
            tbl_val[cfg_idx] <= cfg_val;
        end
    end

    // The read port points at the current entry's register only while
    // scanning; otherwise it is parked on register 0.
    always_comb begin
        rf_addr  = '0;
        mismatch = 1'b0;
        if (state == S_CHECK) begin
            rf_addr  = tbl_reg[idx];
            mismatch = tbl_en[idx] && (rf_data != tbl_val[idx]);
        end
    end

    // Main sequencer: IDLE/DONE wait for start, WAIT counts down the run
    // length (or ends early on halt), CHECK spends exactly one cycle per
    // table entry, enabled or not, so the total latency is fixed.
    // pass is computed on the last CHECK edge including that entry's result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            idx               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            fail_count        <= '0;
            first_fail_idx    <= '0;
            first_fail_actual <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state             <= S_WAIT;
                        cnt               <= run_cycles;
                        busy              <= 1'b1;
                        done              <= 1'b0;
                        pass              <= 1'b0;
                        fail_count        <= '0;
                        first_fail_idx    <= '0;
                        first_fail_actual <= '0;
                    end
                end

                S_WAIT: begin
                    if (halt || (cnt == '0)) begin
                        state <= S_CHECK;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + FC_W'(1);
                        if (fail_count == '0) begin
                            first_fail_idx    <= idx;
                            first_fail_actual <= rf_data;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_result_checker.sv
// tb_regfile_result_checker
//
// Directed bench for regfile_result_checker. A small register-file array
// stands in for the cpu and answers the read port combinationally. Each
// step drives inputs on the falling edge and checks outputs after the
// rising edges it expects, with hand-computed values.
module tb_regfile_result_checker;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic [4:0]  cfg_reg;
    logic [31:0] cfg_val;
    logic [15:0] run_cycles;
    logic        start;
    logic        halt;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail_idx;
    logic [31:0] first_fail_actual;

    logic [31:0] rf [32];

    int vectors;
    int miscompares;

    regfile_result_checker #(
        .DATA_WIDTH(32),
        .REG_ADDR_WIDTH(5),
        .NUM_CHECKS(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_en(cfg_en),
        .cfg_reg(cfg_reg),
        .cfg_val(cfg_val),
        .run_cycles(run_cycles),
        .start(start),
        .halt(halt),
        .rf_addr(rf_addr),
        .rf_data(rf_data),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail_count(fail_count),
        .first_fail_idx(first_fail_idx),
        .first_fail_actual(first_fail_actual)
    );

    assign rf_data = rf[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a run that never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Writes one table entry over a single rising edge.
    task automatic applyStimulus(input logic [2:0] idx, input logic en,
                                 input logic [4:0] rg, input logic [31:0] val);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_en  = en;
        cfg_reg = rg;
        cfg_val = val;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    // Returns on the falling edge right after the edge that samples start.
    task automatic pulseStart(input logic [15:0] cycles);
        @(negedge clk);
        run_cycles = cycles;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_reg     = '0;
        cfg_val     = '0;
        run_cycles  = '0;
        start       = 1'b0;
        halt        = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0]  = 32'h0;
        rf[9]  = 32'h7;
        rf[10] = 32'h2;
        rf[11] = 32'hFFFFFFFF;
        rf[12] = 32'h8;
        rf[13] = 32'h8;
        rf[14] = 32'hFFFFFFFE;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_pass", 32'(pass), 0);
        checkOutput("rst_fc", 32'(fail_count), 0);
        checkOutput("rst_rfaddr", 32'(rf_addr), 0);

        // Matching register file, run_cycles=20: done 29 edges after start
        $display("[TB] step: matching run");
        applyStimulus(3'd0, 1'b1, 5'd9,  32'h7);
        applyStimulus(3'd1, 1'b1, 5'd10, 32'h2);
        applyStimulus(3'd2, 1'b1, 5'd11, 32'hFFFFFFFF);
        applyStimulus(3'd3, 1'b1, 5'd12, 32'h8);
        applyStimulus(3'd4, 1'b1, 5'd13, 32'h8);
        applyStimulus(3'd5, 1'b1, 5'd14, 32'hFFFFFFFE);
        pulseStart(16'd20);
        checkOutput("t1_busy0", 32'(busy), 1);
        repeat (20) @(negedge clk);
        checkOutput("t1_addr_wait", 32'(rf_addr), 0);
        @(negedge clk);
        checkOutput("t1_addr_e0", 32'(rf_addr), 9);
        @(negedge clk);
        checkOutput("t1_addr_e1", 32'(rf_addr), 10);
        repeat (6) @(negedge clk);
        checkOutput("t1_done28", 32'(done), 0);
        checkOutput("t1_busy28", 32'(busy), 1);
        @(negedge clk);
        checkOutput("t1_done29", 32'(done), 1);
        checkOutput("t1_busy29", 32'(busy), 0);
        checkOutput("t1_pass", 32'(pass), 1);
        checkOutput("t1_fc", 32'(fail_count), 0);
        checkOutput("t1_addr_done", 32'(rf_addr), 0);

        // r11 and r13 corrupted: entries 2 and 4 mismatch
        $display("[TB] step: two mismatches");
        rf[11] = 32'h3;
        rf[13] = 32'h5;
        pulseStart(16'd20);
        repeat (28) @(negedge clk);
        checkOutput("t2_done28", 32'(done), 0);
        @(negedge clk);
        checkOutput("t2_done29", 32'(done), 1);
        checkOutput("t2_pass", 32'(pass), 0);
        checkOutput("t2_fc", 32'(fail_count), 2);
        checkOutput("t2_ffi", 32'(first_fail_idx), 2);
        checkOutput("t2_ffa", first_fail_actual, 32'h3);

        // Early halt 5 cycles after start
        $display("[TB] step: halt");
        pulseStart(16'd1000);
        checkOutput("t3_done_clr", 32'(done), 0);
        checkOutput("t3_fc_clr", 32'(fail_count), 0);
        repeat (4) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checkOutput("t3_addr_check", 32'(rf_addr), 9);
        repeat (7) @(negedge clk);
        checkOutput("t3_done12", 32'(done), 0);
        @(negedge clk);
        checkOutput("t3_done13", 32'(done), 1);
        checkOutput("t3_fc", 32'(fail_count), 2);

        // cfg_we and start during CHECK are both ignored
        $display("[TB] step: frozen table");
        pulseStart(16'd3);
        repeat (4) @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = 3'd2;
        cfg_en  = 1'b1;
        cfg_reg = 5'd11;
        cfg_val = 32'h3;
        start   = 1'b1;
        @(negedge clk);
        cfg_we  = 1'b0;
        start   = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("t4_done11", 32'(done), 0);
        checkOutput("t4_busy11", 32'(busy), 1);
        @(negedge clk);
        checkOutput("t4_done12", 32'(done), 1);
        checkOutput("t4_fc", 32'(fail_count), 2);
        checkOutput("t4_ffi", 32'(first_fail_idx), 2);

        // Start in DONE: fresh run, only r13 still wrong
        rf[11] = 32'hFFFFFFFF;
        pulseStart(16'd3);
        checkOutput("t4b_done_clr", 32'(done), 0);
        checkOutput("t4b_ffa_clr", first_fail_actual, 32'h0);
        repeat (12) @(negedge clk);
        checkOutput("t4b_done", 32'(done), 1);
        checkOutput("t4b_fc", 32'(fail_count), 1);
        checkOutput("t4b_ffi", 32'(first_fail_idx), 4);
        checkOutput("t4b_ffa", first_fail_actual, 32'h5);

        // Table writes in DONE keep results; then an all-disabled run
        $display("[TB] step: empty table");
        for (int i = 0; i < 8; i++) applyStimulus(3'(i), 1'b0, 5'd0, 32'h0);
        checkOutput("t5_done_kept", 32'(done), 1);
        checkOutput("t5_fc_kept", 32'(fail_count), 1);
        pulseStart(16'd0);
        repeat (8) @(negedge clk);
        checkOutput("t5_done8", 32'(done), 0);
        @(negedge clk);
        checkOutput("t5_done9", 32'(done), 1);
        checkOutput("t5_pass", 32'(pass), 1);
        checkOutput("t5_fc", 32'(fail_count), 0);

        // Reset during WAIT clears state and table immediately
        $display("[TB] step: reset mid-run");
        applyStimulus(3'd0, 1'b1, 5'd9, 32'd99);
        pulseStart(16'd50);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t6_busy_rst", 32'(busy), 0);
        checkOutput("t6_done_rst", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        pulseStart(16'd2);
        repeat (11) @(negedge clk);
        checkOutput("t6_done", 32'(done), 1);
        checkOutput("t6_pass", 32'(pass), 1);
        checkOutput("t6_fc", 32'(fail_count), 0);

        // Start and cfg_we together in DONE: the run sees the new entry
        $display("[TB] step: start with table write");
        @(negedge clk);
        run_cycles = 16'd2;
        start      = 1'b1;
        cfg_we     = 1'b1;
        cfg_idx    = 3'd7;
        cfg_en     = 1'b1;
        cfg_reg    = 5'd10;
        cfg_val    = 32'h5;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t7_addr_e7", 32'(rf_addr), 10);
        @(negedge clk);
        checkOutput("t7_done", 32'(done), 1);
        checkOutput("t7_pass", 32'(pass), 0);
        checkOutput("t7_fc", 32'(fail_count), 1);
        checkOutput("t7_ffi", 32'(first_fail_idx), 7);
        checkOutput("t7_ffa", first_fail_actual, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
